code_patch_loader: RTL and testbench

CODE_PATCH_LOADER -- requirements
Module: code_patch_loader

---
 rtl/code_patch_loader.sv | 145 ++++++++++++++
 tb/tb_code_patch_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_patch_loader.sv
// Byte-serial loader for a patch table: header (sync 0xA + index) then three data bytes, MSB first.
// Define CODE_PATCH_PARITY_EN to require a fifth XOR-parity byte after the data bytes.
module code_patch_loader #(
    parameter int NUM_PATCH = 3,
    parameter int PATCH_W   = 22,
    parameter int TIMEOUT   = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_pat_gen_i,
    input  logic               si_write_i,
    input  logic [7:0]         si_data_i,
    input  logic               patch_ack_i,
    output logic               patch_wr_o,
    output logic [3:0]         patch_idx_o,
    output logic [PATCH_W-1:0] patch_data_o,
    output logic               busy_o,
    output logic               err_o,
    output logic [1:0]         err_code_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PUSH = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [4:0] NUM_P5 = 5'(NUM_PATCH);
    localparam logic [7:0] TMO    = 8'(TIMEOUT);

    logic [1:0]         r_state;
    logic [1:0]         r_cnt;
    logic [7:0]         r_timer;
    logic [3:0]         r_idx;
    logic [PATCH_W-1:0] r_data;
    logic [1:0]         r_code;

    logic [23:0]        w_word;
    logic               w_hdr_ok;
    logic               w_range_ok;
    logic               w_par_ok;
    logic [1:0]         w_last;

`ifdef CODE_PATCH_PARITY_EN
    // The full word is already registered when the parity byte arrives.
    logic [23:0] r_word;
    logic [7:0]  r_xor;
    assign w_word   = r_word;
    assign w_par_ok = (r_xor == si_data_i);
    assign w_last   = 2'd3;
`else
    logic [15:0] r_word;
    assign w_word   = {r_word, si_data_i};
    assign w_par_ok = 1'b1;
    assign w_last   = 2'd2;
`endif

    assign w_hdr_ok   = (si_data_i[7:4] == 4'hA) && ({1'b0, si_data_i[3:0]} < NUM_P5);
    assign w_range_ok = ((w_word >> PATCH_W) == 24'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_timer <= 8'd0;
            r_idx   <= 4'd0;
            r_data  <= '0;
            r_code  <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (si_write_i && cfg_pat_gen_i) begin
                        if (w_hdr_ok) begin
                            r_state <= S_DATA;
                            r_idx   <= si_data_i[3:0];
                            r_cnt   <= 2'd0;
                            r_timer <= 8'd0;
                        end else begin
                            r_state <= S_ERR;
                            r_code  <= 2'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (!cfg_pat_gen_i) begin
                        r_state <= S_IDLE;
                    end else if (si_write_i) begin
                        r_timer <= 8'd0;
                        r_cnt   <= r_cnt + 2'd1;
                        if (r_cnt == w_last) begin
                            if (!w_par_ok) begin
                                r_state <= S_ERR;
                                r_code  <= 2'd3;
                            end else if (!w_range_ok) begin
                                r_state <= S_ERR;
                                r_code  <= 2'd2;
                            end else begin
                                r_state <= S_PUSH;
                                r_data  <= w_word[PATCH_W-1:0];
                            end
                        end
                    end else if (r_timer + 8'd1 == TMO) begin
                        r_state <= S_ERR;
                        r_code  <= 2'd3;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_PUSH: begin
                    if (patch_ack_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Frame payload registers carry no control meaning, so they skip reset.
`ifdef CODE_PATCH_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (r_state == S_IDLE && si_write_i) begin
            r_xor <= si_data_i;
        end else if (r_state == S_DATA && si_write_i) begin
            r_xor  <= r_xor ^ si_data_i;
            r_word <= {r_word[15:0], si_data_i};
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (r_state == S_DATA && si_write_i) begin
            r_word <= {r_word[7:0], si_data_i};
        end
    end
`endif

    assign patch_wr_o   = (r_state == S_PUSH);
    assign patch_idx_o  = r_idx;
    assign patch_data_o = r_data;
    assign busy_o       = (r_state != S_IDLE);
    assign err_o        = (r_state == S_ERR);
    assign err_code_o   = r_code;

endmodule

// File: tb/tb_code_patch_loader.sv
// Self-checking bench for code_patch_loader: fixed vector table, corner-case sequences,
// and randomized frames scored against a rule-level reference model.
module tb_code_patch_loader;

    localparam int NUM_PATCH = 3;
    localparam int PATCH_W   = 22;
    localparam int TIMEOUT   = 255;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               cfg_pat_gen_i;
    logic               si_write_i;
    logic [7:0]         si_data_i;
    logic               patch_ack_i;
    logic               patch_wr_o;
    logic [3:0]         patch_idx_o;
    logic [PATCH_W-1:0] patch_data_o;
    logic               busy_o;
    logic               err_o;
    logic [1:0]         err_code_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    code_patch_loader #(
        .NUM_PATCH(NUM_PATCH),
        .PATCH_W  (PATCH_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cfg_pat_gen_i(cfg_pat_gen_i),
        .si_write_i   (si_write_i),
        .si_data_i    (si_data_i),
        .patch_ack_i  (patch_ack_i),
        .patch_wr_o   (patch_wr_o),
        .patch_idx_o  (patch_idx_o),
        .patch_data_o (patch_data_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .err_code_o   (err_code_o)
    );

    typedef struct {
        logic [7:0]  h, d0, d1, d2;
        int          ack_dly;   // negative: ack held high for the whole frame
        logic        wr;
        logic [1:0]  code;
        logic [3:0]  idx;
        logic [23:0] data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        si_write_i = 1'b1;
        si_data_i  = b;
        tick();
        si_write_i = 1'b0;
    endtask

    // Outcome of one frame derived from the frame rules with plain arithmetic.
    function automatic void model(input logic [7:0] h, d0, d1, d2,
                                  output logic wr, output logic [1:0] code,
                                  output logic [3:0] idx, output logic [23:0] data);
        int word;
        word = int'({d0, d1, d2});
        wr   = 1'b0;
        code = 2'd0;
        idx  = h[3:0];
        data = 24'(word);
        if (h[7:4] != 4'hA || int'(h[3:0]) >= NUM_PATCH) code = 2'd1;
        else if (word >= (1 << PATCH_W))                 code = 2'd2;
        else                                              wr   = 1'b1;
    endfunction

    task automatic do_frame(input vec_t v, input string tag);
        if (v.ack_dly < 0) patch_ack_i = 1'b1;
        send(v.h);
        if (v.code == 2'd1) begin
            chk({tag, "_hdr_err"}, 32'(err_o), 32'd1);
            chk({tag, "_hdr_code"}, 32'(err_code_o), 32'd1);
            chk({tag, "_hdr_nowr"}, 32'(patch_wr_o), 32'd0);
            patch_ack_i = 1'b0;
            tick();
            chk({tag, "_hdr_idle"}, 32'(busy_o), 32'd0);
            return;
        end
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
        send(v.d0);
        send(v.d1);
        send(v.d2);
`ifdef CODE_PATCH_PARITY_EN
        send(v.h ^ v.d0 ^ v.d1 ^ v.d2);
`endif
        if (v.wr) begin
            chk({tag, "_wr"}, 32'(patch_wr_o), 32'd1);
            chk({tag, "_idx"}, 32'(patch_idx_o), 32'(v.idx));
            chk({tag, "_data"}, 32'(patch_data_o), 32'(v.data));
            for (int i = 0; i < v.ack_dly; i++) begin
                si_write_i = 1'b1;
                si_data_i  = 8'hA0;
                tick();
                chk({tag, "_wr_hold"}, 32'(patch_wr_o), 32'd1);
                chk({tag, "_data_hold"}, 32'(patch_data_o), 32'(v.data));
            end
            patch_ack_i = 1'b1;
            si_write_i  = 1'b1;
            si_data_i   = 8'hA0;
            tick();
            si_write_i  = 1'b0;
            patch_ack_i = 1'b0;
            chk({tag, "_wr_done"}, 32'(patch_wr_o), 32'd0);
            chk({tag, "_idle"}, 32'(busy_o), 32'd0);
            chk({tag, "_noerr"}, 32'(err_o), 32'd0);
        end else begin
            chk({tag, "_err"}, 32'(err_o), 32'd1);
            chk({tag, "_code"}, 32'(err_code_o), 32'(v.code));
            chk({tag, "_nowr"}, 32'(patch_wr_o), 32'd0);
            patch_ack_i = 1'b0;
            tick();
            chk({tag, "_err_1cyc"}, 32'(err_o), 32'd0);
            chk({tag, "_err_idle"}, 32'(busy_o), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];
        vec_t v;
        int   early;

        tbl[0] = '{8'hA1, 8'h12, 8'h34, 8'h56,  2, 1'b1, 2'd0, 4'd1, 24'h123456};
        tbl[1] = '{8'hA2, 8'h03, 8'hFF, 8'hFF, -1, 1'b1, 2'd0, 4'd2, 24'h03FFFF};
        tbl[2] = '{8'hA3, 8'h00, 8'h00, 8'h00,  0, 1'b0, 2'd1, 4'd3, 24'h0};
        tbl[3] = '{8'h5C, 8'h00, 8'h00, 8'h00,  0, 1'b0, 2'd1, 4'd12, 24'h0};
        tbl[4] = '{8'hA1, 8'h40, 8'h00, 8'h00,  0, 1'b0, 2'd2, 4'd1, 24'h400000};
        tbl[5] = '{8'hA0, 8'h3F, 8'hFF, 8'hFF,  1, 1'b1, 2'd0, 4'd0, 24'h3FFFFF};
        tbl[6] = '{8'hA2, 8'h80, 8'h00, 8'h01,  0, 1'b0, 2'd2, 4'd2, 24'h800001};
        tbl[7] = '{8'hAF, 8'h00, 8'h00, 8'h00,  0, 1'b0, 2'd1, 4'd15, 24'h0};
        tbl[8] = '{8'hA0, 8'h00, 8'h00, 8'h00,  0, 1'b1, 2'd0, 4'd0, 24'h0};

        rst_i = 1'b1; cfg_pat_gen_i = 1'b0; si_write_i = 1'b0;
        si_data_i = 8'h00; patch_ack_i = 1'b0;
        tick(); tick();
        chk("rst_wr",   32'(patch_wr_o),   32'd0);
        chk("rst_idx",  32'(patch_idx_o),  32'd0);
        chk("rst_data", 32'(patch_data_o), 32'd0);
        chk("rst_busy", 32'(busy_o),       32'd0);
        chk("rst_err",  32'(err_o),        32'd0);
        chk("rst_code", 32'(err_code_o),   32'd0);
        rst_i = 1'b0;
        cfg_pat_gen_i = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            do_frame(tbl[i], $sformatf("vec%0d", i));
        end

        // Two back-to-back bad headers, each with its own error pulse.
        send(8'hA3);
        chk("hdr2_err_a", 32'(err_o), 32'd1);
        tick();
        send(8'h57);
        chk("hdr2_err_b", 32'(err_o), 32'd1);
        chk("hdr2_code_b", 32'(err_code_o), 32'd1);
        tick();

        // A header landing in the ERR cycle is dropped.
        send(8'h55);
        chk("errdrop_err", 32'(err_o), 32'd1);
        send(8'hA0);
        chk("errdrop_idle", 32'(busy_o), 32'd0);

        // Inter-byte timeout fires after exactly TIMEOUT idle cycles.
        send(8'hA0);
        send(8'h01);
        early = (err_o !== 1'b0) ? 1 : 0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            if (err_o !== 1'b0) early++;
        end
        chk("tmo_early", 32'(early), 32'd0);
        tick();
        chk("tmo_err",  32'(err_o),      32'd1);
        chk("tmo_code", 32'(err_code_o), 32'd3);
        tick();
        chk("tmo_idle", 32'(busy_o), 32'd0);
        v = '{8'hA0, 8'h00, 8'h00, 8'h07, 0, 1'b1, 2'd0, 4'd0, 24'h000007};
        do_frame(v, "after_tmo");

        // Each accepted byte restarts the timer.
        send(8'hA1);
        send(8'h00);
        repeat (200) tick();
        send(8'h00);
        repeat (200) tick();
        chk("tmo_clr_noerr", 32'(err_o), 32'd0);
        send(8'h2A);
`ifdef CODE_PATCH_PARITY_EN
        send(8'hA1 ^ 8'h2A);
`endif
        chk("tmo_clr_wr",   32'(patch_wr_o),   32'd1);
        chk("tmo_clr_data", 32'(patch_data_o), 32'h2A);
        patch_ack_i = 1'b1; tick(); patch_ack_i = 1'b0;

        // Reset mid-frame: outputs cleared, no error pulse.
        send(8'hA1);
        send(8'h00);
        rst_i = 1'b1;
        tick();
        chk("rstmid_busy", 32'(busy_o),     32'd0);
        chk("rstmid_err",  32'(err_o),      32'd0);
        chk("rstmid_code", 32'(err_code_o), 32'd0);
        chk("rstmid_data", 32'(patch_data_o), 32'd0);
        rst_i = 1'b0;
        tick();
        chk("rstmid_err2", 32'(err_o), 32'd0);

        // Reset while waiting for ack.
        send(8'hA2); send(8'h00); send(8'h00); send(8'h05);
`ifdef CODE_PATCH_PARITY_EN
        send(8'hA2 ^ 8'h05);
`endif
        chk("rstpush_wr1", 32'(patch_wr_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rstpush_wr0",  32'(patch_wr_o),  32'd0);
        chk("rstpush_idx",  32'(patch_idx_o), 32'd0);
        chk("rstpush_busy", 32'(busy_o),      32'd0);
        chk("rstpush_err",  32'(err_o),       32'd0);

        // Enable drop in DATA aborts silently; bytes ignored while disabled.
        send(8'hA1);
        cfg_pat_gen_i = 1'b0;
        tick();
        chk("cfgdrop_busy", 32'(busy_o), 32'd0);
        chk("cfgdrop_err",  32'(err_o),  32'd0);
        send(8'hA1);
        chk("cfgoff_ignore", 32'(busy_o), 32'd0);
        send(8'h33);
        chk("cfgoff_noerr", 32'(err_o), 32'd0);
        cfg_pat_gen_i = 1'b1;

        // Enable drop in PUSH does not disturb the transfer.
        send(8'hA2); send(8'h00); send(8'h00); send(8'h09);
`ifdef CODE_PATCH_PARITY_EN
        send(8'hA2 ^ 8'h09);
`endif
        cfg_pat_gen_i = 1'b0;
        chk("cfgpush_wr", 32'(patch_wr_o), 32'd1);
        tick();
        chk("cfgpush_hold", 32'(patch_wr_o), 32'd1);
        chk("cfgpush_data", 32'(patch_data_o), 32'h9);
        patch_ack_i = 1'b1; tick(); patch_ack_i = 1'b0;
        chk("cfgpush_done", 32'(busy_o), 32'd0);
        cfg_pat_gen_i = 1'b1;

`ifdef CODE_PATCH_PARITY_EN
        send(8'hA1); send(8'h00); send(8'h00); send(8'h01); send(8'hA1);
        chk("par_err",  32'(err_o),      32'd1);
        chk("par_code", 32'(err_code_o), 32'd3);
        tick();
`endif

        for (int n = 0; n < 40; n++) begin
            v.h  = {($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hA, 4'($urandom_range(0, 4))};
            v.d0 = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63));
            v.d1 = 8'($urandom);
            v.d2 = 8'($urandom);
            v.ack_dly = int'($urandom_range(0, 4)) - 1;
            model(v.h, v.d0, v.d1, v.d2, v.wr, v.code, v.idx, v.data);
            do_frame(v, $sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
